// File: rtl/hamming_row_decoder_60bit.sv
// Hamming(15,11) row decoder: 4 rows per 60-bit frame, one row per clock.
// Optional corrected-row counter: HAMMING_ROW_DECODER_ERR_COUNT_EN.
module hamming_row_decoder_60bit #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [59:0] in_frame,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [43:0] out_data,
  output logic [3:0]  out_err,
  output logic [15:0] out_syndrome
`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_count_clr
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [59:0] frame_q, frame_d;
  logic [43:0] data_q, data_d;
  logic [3:0]  err_q, err_d;
  logic [15:0] syn_q, syn_d;

  logic [14:0] cw;
  logic [3:0]  syn;
  logic [14:0] flip;
  logic [14:0] fixed;
  logic [10:0] row_data;

  // Single-row syndrome, correction and data extraction.
  always_comb begin
    cw       = frame_q[15*row_q +: 15];
    syn[0]   = ^(cw & 15'h5555);
    syn[1]   = ^(cw & 15'h6666);
    syn[2]   = ^(cw & 15'h7878);
    syn[3]   = ^(cw & 15'h7F80);
    flip     = '0;
    if (syn != 4'd0) flip = 15'd1 << (syn - 4'd1);
    fixed    = cw ^ flip;
    row_data = {fixed[14:8], fixed[6:4], fixed[2]};
  end

  // Frame FSM: accept, decode four rows, hold until consumed.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    frame_d = frame_q;
    data_d  = data_q;
    err_d   = err_q;
    syn_d   = syn_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          frame_d = in_frame;
          row_d   = 2'd0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        data_d[11*row_q +: 11] = row_data;
        err_d[row_q]           = (syn != 4'd0);
        syn_d[4*row_q +: 4]    = syn;
        row_d                  = row_q + 2'd1;
        if (row_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      frame_q <= '0;
      data_q  <= '0;
      err_q   <= '0;
      syn_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      frame_q <= frame_d;
      data_q  <= data_d;
      err_q   <= err_d;
      syn_q   <= syn_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_data     = data_q;
  assign out_err      = err_q;
  assign out_syndrome = syn_q;

`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of corrected rows; clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (err_count_clr) begin
      cnt_d = '0;
    end else if (state_q == DECODE && syn != 4'd0 && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_hamming_row_decoder_60bit.sv
// Bench for hamming_row_decoder_60bit: directed frames plus random
// frames checked against a position-arithmetic Hamming model.
module tb_hamming_row_decoder_60bit;

`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [59:0] in_frame = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [43:0] out_data;
  logic [3:0]  out_err;
  logic [15:0] out_syndrome;
`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
  logic [CW-1:0] err_count;
  logic          err_count_clr = 1'b0;
`endif

  hamming_row_decoder_60bit #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_frame     (in_frame),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_err      (out_err),
    .out_syndrome (out_syndrome)
`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
    ,
    .err_count    (err_count),
    .err_count_clr(err_count_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_exp = 0;

  logic [43:0] got_d;
  logic [3:0]  got_e;
  logic [15:0] got_s;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: syndrome = XOR of positions holding a 1; data = non-power-of-2
  // positions in ascending order after flipping the bad position.
  function automatic void ref_decode(input logic [59:0] f,
                                     output logic [43:0] d,
                                     output logic [3:0] e,
                                     output logic [15:0] s);
    logic [14:0] w;
    int sy, k;
    d = '0; e = '0; s = '0;
    for (int r = 0; r < 4; r++) begin
      w = f[r*15 +: 15];
      sy = 0;
      for (int p = 1; p <= 15; p++) if (w[p-1]) sy = sy ^ p;
      if (sy != 0) w[sy-1] = ~w[sy-1];
      k = 0;
      for (int p = 1; p <= 15; p++) begin
        if ((p & (p - 1)) != 0) begin
          d[r*11 + k] = w[p-1];
          k++;
        end
      end
      e[r] = (sy != 0);
      s[r*4 +: 4] = 4'(sy);
    end
  endfunction

  function automatic logic [59:0] rnd_frame();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[59:0];
  endfunction

  task automatic run_frame(input logic [59:0] f, input int hold,
                           input bit clr_first);
    logic [43:0] ed;
    logic [3:0]  ee;
    logic [15:0] es;
    int lat;
    ref_decode(f, ed, ee, es);
    check_eq("rdy_before", in_ready, 1'b1);
    out_ready = (hold == 0);
    in_valid = 1'b1;
    in_frame = f;
    step();
    in_valid = 1'b0;
    in_frame = rnd_frame();
`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
    err_count_clr = clr_first;
`endif
    for (int r = 0; r < 4; r++) begin
      if (r == 0 && clr_first) cnt_exp = 0;
      else if (ee[r] && cnt_exp < (1 << CW) - 1) cnt_exp++;
    end
    lat = 0;
    while (!out_valid && lat < 16) begin
      check_eq("rdy_busy", in_ready, 1'b0);
      step();
`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
      err_count_clr = 1'b0;
`endif
      lat++;
    end
    check_eq("latency", lat, 4);
    check_eq("data", out_data, ed);
    check_eq("err", out_err, ee);
    check_eq("syn", out_syndrome, es);
`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
    check_eq("cnt", err_count, cnt_exp);
`endif
    got_d = out_data;
    got_e = out_err;
    got_s = out_syndrome;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_frame = rnd_frame();
      step();
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_rdy", in_ready, 1'b0);
      check_eq("hold_data", out_data, ed);
      check_eq("hold_err", out_err, ee);
      check_eq("hold_syn", out_syndrome, es);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("hs_valid", out_valid, 1'b0);
    check_eq("hs_rdy", in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [59:0] f;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_rdy", in_ready, 1'b1);
    check_eq("rst_data", out_data, 44'd0);
    check_eq("rst_err", out_err, 4'd0);
    check_eq("rst_syn", out_syndrome, 16'd0);
`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
    check_eq("rst_cnt", err_count, 0);
`endif

    // Clean frame.
    run_frame(60'd0, 0, 1'b0);
    check_eq("clean_data", got_d, 44'd0);
    check_eq("clean_err", got_e, 4'd0);
    check_eq("clean_syn", got_s, 16'd0);

    // Data-bit error in row 0 at p3.
    f = '0; f[2] = 1'b1;
    run_frame(f, 0, 1'b0);
    check_eq("p3_data", got_d, 44'd0);
    check_eq("p3_err", got_e, 4'b0001);
    check_eq("p3_syn", got_s, 16'h0003);

    // Parity error row 1, p15 error row 3.
    f = '0; f[15] = 1'b1; f[59] = 1'b1;
    run_frame(f, 0, 1'b0);
    check_eq("multi_data", got_d, 44'd0);
    check_eq("multi_err", got_e, 4'b1010);
    check_eq("multi_syn", got_s, 16'hF010);

    // All-ones rows, row 2 p15 flipped.
    f = {4{15'h7FFF}}; f[44] = 1'b0;
    run_frame(f, 0, 1'b0);
    check_eq("ones_data", got_d, 44'hFFFFFFFFFFF);
    check_eq("ones_err", got_e, 4'b0100);
    check_eq("ones_syn", got_s, 16'h0F00);

    // Backpressure for 10 cycles with a competing frame offered.
    run_frame(rnd_frame(), 10, 1'b0);
    step();
    check_eq("no_consume", in_ready, 1'b1);

    // Reset in the middle of DECODE.
    in_valid = 1'b1;
    in_frame = rnd_frame() | 60'd1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_exp = 0;
    check_eq("mrst_valid", out_valid, 1'b0);
    check_eq("mrst_rdy", in_ready, 1'b1);
    check_eq("mrst_data", out_data, 44'd0);
    check_eq("mrst_err", out_err, 4'd0);
    check_eq("mrst_syn", out_syndrome, 16'd0);
    step();
    check_eq("mrst_idle", in_ready, 1'b1);

`ifdef HAMMING_ROW_DECODER_ERR_COUNT_EN
    // Saturation then clear against a simultaneous erroneous row.
    for (int i = 0; i < 4; i++) begin
      f = '0; f[15*(i%4) + 4] = 1'b1;
      run_frame(f, 0, 1'b0);
    end
    check_eq("cnt_sat", err_count, 3);
    f = '0; f[2] = 1'b1;
    run_frame(f, 0, 1'b1);
    check_eq("cnt_clr", err_count, 0);
`endif

    // Random frames with random backpressure.
    for (int i = 0; i < 40; i++) begin
      run_frame(rnd_frame(), $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
